// File: rtl/lottery_pkg.sv
// Shared definitions for the lottery ticket player.
// Holds the FSM state enum, the BCD limit, the checker prize codes, the
// ticket length and small helpers to pick and validate ticket nibbles.
// No ports; imported by lottery_ticket_player.
package lottery_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CLR,
        ST_PICK,
        ST_SEND,
        ST_GAP,
        ST_FIN,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [1:0] PRM_NONE   = 2'b00;
    localparam logic [1:0] PRM_P1     = 2'b01;
    localparam logic [1:0] PRM_P2     = 2'b10;
    localparam int         NUM_DIGITS = 5;

    // Digit 0 is the most significant nibble, the first one sent.
    function automatic logic [3:0] nibble_at(input logic [19:0] t, input logic [2:0] i);
        logic [3:0] n;
        case (i)
            3'd0:    n = t[19:16];
            3'd1:    n = t[15:12];
            3'd2:    n = t[11:8];
            3'd3:    n = t[7:4];
            3'd4:    n = t[3:0];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic ticket_is_bcd(input logic [19:0] t);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (nibble_at(t, 3'(k)) > BCD_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lottery_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-low reset, loads the seed
//   enable in  1   advance one step per cycle when high
//   value  out 16  current register contents
// A zero seed would lock the register at zero, so it is replaced by 1.
module lottery_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] value
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic feedback;

    assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      value <= INIT;
        else if (enable) value <= {feedback, value[15:1]};
    end

endmodule

// File: rtl/lottery_ticket_player.sv
// Automatic bettor driving the lottery checker's num/insert/finish interface.
// Per game: clear the checker, send 5 BCD digits (LFSR or fixed ticket),
// strobe finish, wait for the checker to settle and register its prize code.
// Ports:
//   clk, reset (async active-low)
//   start, mode, ticket[19:0]          game launch controls, sampled in IDLE
//   prm[1:0]                           prize code from the checker
//   num[3:0], insert, finish, game_rst checker interface
//   busy, done, err                    game status
//   prize[1:0], digits[19:0]           last completed game
//   games, wins [CNT_W-1:0]            saturating board counters
module lottery_ticket_player
    import lottery_pkg::*;
#(
    parameter int          GAP_CYCLES  = 1,
    parameter int          RESULT_WAIT = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [19:0]      ticket,
    input  logic [1:0]       prm,
    output logic [3:0]       num,
    output logic             insert,
    output logic             finish,
    output logic             game_rst,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       prize,
    output logic [19:0]      digits,
    output logic [CNT_W-1:0] games,
    output logic [CNT_W-1:0] wins
);

    state_t      state, next_state;
    logic        mode_q;
    logic [19:0] ticket_q;
    logic [2:0]  idx;
    logic [2:0]  load_idx;
    logic [3:0]  digit_q;
    logic [3:0]  load_digit;
    logic [7:0]  cnt;
    logic [15:0] lfsr_value;
    logic [11:0] lfsr_unused;

    lottery_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (1'b1),
        .value  (lfsr_value)
    );

    // Only the low nibble feeds digit selection.
    assign lfsr_unused = lfsr_value[15:4];

    // Outputs are decoded from the state alone, so an async reset forces
    // every strobe low immediately. In fixed mode the ticket nibble is ready
    // without a pick cycle, so after the first digit the FSM returns straight
    // to SEND and consecutive inserts are exactly GAP_CYCLES+1 apart.
    always_comb begin
        next_state = state;
        insert     = 1'b0;
        finish     = 1'b0;
        game_rst   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        num        = 4'd0;
        case (state)
            ST_IDLE:  if (start) next_state = ST_CHECK;
            ST_CHECK: begin
                if (mode_q && !ticket_is_bcd(ticket_q)) begin
                    err        = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_CLR;
                end
            end
            ST_CLR: begin
                game_rst   = 1'b1;
                next_state = ST_PICK;
            end
            ST_PICK: begin
                if (mode_q || (lfsr_value[3:0] <= BCD_MAX)) next_state = ST_SEND;
            end
            ST_SEND: begin
                insert = 1'b1;
                num    = digit_q;
                if (idx == 3'(NUM_DIGITS - 1)) next_state = ST_FIN;
                else if (GAP_CYCLES == 0)      next_state = mode_q ? ST_SEND : ST_PICK;
                else                           next_state = ST_GAP;
            end
            ST_GAP: begin
                if (cnt == 8'(GAP_CYCLES - 1)) next_state = mode_q ? ST_SEND : ST_PICK;
            end
            ST_FIN: begin
                finish     = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == 8'(RESULT_WAIT - 1)) next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // busy drops in the abort cycle so it never overlaps the err pulse.
    assign busy = (state != ST_IDLE) && !err;

    // The digit is loaded on entry to SEND; a SEND->SEND hop needs the next index.
    assign load_idx   = (state == ST_SEND) ? idx + 3'd1 : idx;
    assign load_digit = mode_q ? nibble_at(ticket_q, load_idx) : lfsr_value[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Datapath: launch latches, digit bookkeeping, wait counter, prize and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= 1'b0;
            ticket_q <= 20'd0;
            idx      <= 3'd0;
            digit_q  <= 4'd0;
            cnt      <= 8'd0;
            prize    <= PRM_NONE;
            digits   <= 20'd0;
            games    <= '0;
            wins     <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                mode_q   <= mode;
                ticket_q <= ticket;
            end
            if (state == ST_CLR) idx <= 3'd0;
            if (state == ST_SEND && idx != 3'(NUM_DIGITS - 1)) idx <= idx + 3'd1;
            if (next_state == ST_SEND) digit_q <= load_digit;
            if (state == ST_SEND) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (idx == 3'(k)) digits[19-4*k -: 4] <= digit_q;
                end
            end
            if (state == ST_GAP || state == ST_WAIT) cnt <= cnt + 8'd1;
            else                                     cnt <= 8'd0;
            if (state == ST_WAIT && cnt == 8'(RESULT_WAIT - 1)) prize <= prm;
            if (state == ST_DONE) begin
                if (games != '1) games <= games + CNT_W'(1);
                if (prize != PRM_NONE && wins != '1) wins <= wins + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lottery_ticket_player.sv
// Self-checking bench for lottery_ticket_player.
// A behavioural checker model (target ticket 50967: 5 matching digits give
// prize 01, exactly 4 give prize 10) answers the player; a scoreboard
// recomputes the expected prize, digits and saturating counters per game.
module tb_lottery_ticket_player;

    localparam int          GAP    = 1;
    localparam int          RW     = 3;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [19:0] TARGET = 20'h50967;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [19:0] ticket;
    logic [1:0]  prm;
    logic [3:0]  num;
    logic        insert, finish, game_rst, busy, done, err;
    logic [1:0]  prize;
    logic [19:0] digits;
    logic [7:0]  games, wins;

    int checks   = 0;
    int failures = 0;

    lottery_ticket_player #(
        .GAP_CYCLES (GAP),
        .RESULT_WAIT(RW),
        .LFSR_SEED  (SEED),
        .CNT_W      (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .ticket  (ticket),
        .prm     (prm),
        .num     (num),
        .insert  (insert),
        .finish  (finish),
        .game_rst(game_rst),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .prize   (prize),
        .digits  (digits),
        .games   (games),
        .wins    (wins)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] prize_of(input logic [19:0] tk);
        int hits = 0;
        for (int i = 0; i < 5; i++) begin
            if (tk[19-4*i -: 4] == TARGET[19-4*i -: 4]) hits++;
        end
        if (hits == 5) return 2'b01;
        if (hits == 4) return 2'b10;
        return 2'b00;
    endfunction

    // Reference LFSR written as the textbook shift formula.
    logic [15:0] ref_lfsr;
    logic [15:0] prev_lfsr = 16'h0;
    always @(posedge clk or negedge reset) begin
        if (!reset) ref_lfsr <= SEED;
        else ref_lfsr <= (ref_lfsr >> 1) |
                         (16'(((ref_lfsr ^ (ref_lfsr >> 2) ^ (ref_lfsr >> 3) ^ (ref_lfsr >> 5)) & 16'h1)) << 15);
    end

    // Checker model: collects digits, answers two cycles after finish.
    logic [19:0] ck_packed;
    int          ck_count;
    bit          ck_stage;
    always @(negedge clk) begin
        if (!reset) begin
            prm = 2'b00; ck_packed = '0; ck_count = 0; ck_stage = 0;
        end else begin
            if (ck_stage) begin
                prm = (ck_count == 5) ? prize_of(ck_packed) : 2'b00;
                ck_stage = 0;
            end
            if (game_rst) begin prm = 2'b00; ck_packed = '0; ck_count = 0; end
            if (insert) begin ck_packed = {ck_packed[15:0], num}; ck_count++; end
            if (finish) ck_stage = 1;
        end
    end

    // Scoreboard and interface property monitor.
    logic [19:0] mon_packed;
    int          mon_count, last_ins, cyc = 0, done_count = 0;
    logic [7:0]  exp_games, exp_wins;
    logic [1:0]  exp_prize;
    bit          cnt_pending;
    always @(negedge clk) begin
        if (!reset) begin
            mon_packed = '0; mon_count = 0; last_ins = -1;
            exp_games = 0; exp_wins = 0; cnt_pending = 0;
        end else begin
            cyc++;
            if (cnt_pending) begin
                checkOutput("games", games, exp_games);
                checkOutput("wins", wins, exp_wins);
                cnt_pending = 0;
            end
            if (game_rst) begin mon_packed = '0; mon_count = 0; last_ins = -1; end
            if (insert) begin
                checkOutput("ins_order", {game_rst, finish}, 0);
                checkOutput("num_bcd", num <= 4'd9, 1);
                if (last_ins >= 0) checkOutput("ins_spacing", (cyc - last_ins) >= GAP + 1, 1);
                if (!mode) checkOutput("num_lfsr", num, prev_lfsr[3:0]);
                mon_packed = {mon_packed[15:0], num};
                mon_count++;
                last_ins = cyc;
            end else begin
                checkOutput("num_idle", num, 0);
            end
            if (done) begin
                checkOutput("dig_count", mon_count, 5);
                checkOutput("digits", digits, mon_packed);
                exp_prize = prize_of(mon_packed);
                checkOutput("prize", prize, exp_prize);
                if (exp_games != 8'hFF) exp_games++;
                if (exp_prize != 2'b00 && exp_wins != 8'hFF) exp_wins++;
                cnt_pending = 1;
                done_count++;
            end
        end
        prev_lfsr = ref_lfsr;
    end

    // One game from a start pulse; times are cycles after the sampling edge.
    task automatic applyStimulus(input logic m, input logic [19:0] t,
                                 output int first_ins, output int done_at,
                                 output int err_at, output int n_rst, output int n_ins);
        first_ins = -1; done_at = -1; err_at = -1; n_rst = 0; n_ins = 0;
        @(negedge clk); mode = m; ticket = t; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (insert) begin
                if (first_ins < 0) first_ins = k;
                n_ins++;
            end
            if (game_rst) n_rst++;
            if (err)  begin err_at = k;  break; end
            if (done) begin done_at = k; break; end
            @(negedge clk);
        end
        if (done_at < 0 && err_at < 0) checkOutput("timeout", {done, err} != 0, 1);
    endtask

    int fi, da, ea, nr, ni, base, seen;

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b1; ticket = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outs", {num, insert, finish, game_rst, busy, done, err, prize, digits, games, wins}, 0);
        reset = 1'b1;
        @(negedge clk);

        // T1: winning ticket with latency checks
        applyStimulus(1'b1, 20'h50967, fi, da, ea, nr, ni);
        checkOutput("T1_first_ins", fi, 3);
        checkOutput("T1_done_lat", da, 3 + 5 + 4*GAP + 1 + RW);
        checkOutput("T1_no_err", ea < 0, 1);
        checkOutput("T1_rst_cnt", nr, 1);
        checkOutput("T1_ins_cnt", ni, 5);
        checkOutput("T1_prize", prize, 2'b01);
        checkOutput("T1_digits", digits, 20'h50967);
        @(negedge clk);
        checkOutput("T1_games", games, 1);
        checkOutput("T1_wins", wins, 1);
        checkOutput("T1_idle", busy, 0);

        // T2: one digit off gives the second prize
        applyStimulus(1'b1, 20'h50167, fi, da, ea, nr, ni);
        checkOutput("T2_prize", prize, 2'b10);
        @(negedge clk);
        checkOutput("T2_games", games, 2);
        checkOutput("T2_wins", wins, 2);

        // T3: no match
        applyStimulus(1'b1, 20'h12345, fi, da, ea, nr, ni);
        checkOutput("T3_prize", prize, 2'b00);
        @(negedge clk);
        checkOutput("T3_games", games, 3);
        checkOutput("T3_wins", wins, 2);

        // T4: non-BCD nibble aborts in the check cycle
        applyStimulus(1'b1, 20'h5A967, fi, da, ea, nr, ni);
        checkOutput("T4_err_at", ea, 0);
        checkOutput("T4_busy_in_err", busy, 0);
        checkOutput("T4_no_ins", ni, 0);
        checkOutput("T4_no_rst", nr, 0);
        repeat (3) @(negedge clk);
        checkOutput("T4_games", games, 3);
        checkOutput("T4_wins", wins, 2);
        checkOutput("T4_idle", busy, 0);

        // T5: random digits, start held for 300 games
        base = done_count;
        mode = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done_count >= base + 300) break;
        end
        checkOutput("T5_game_count", done_count >= base + 300, 1);
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        @(negedge clk);
        checkOutput("T5_idle", busy, 0);
        checkOutput("T5_sat", games, 8'hFF);

        // T6: reset during the third digit
        @(negedge clk); mode = 1'b1; ticket = 20'h50967; start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (insert) seen++;
            if (seen == 3) break;
            @(negedge clk);
        end
        checkOutput("T6_third_digit", seen, 3);
        reset = 1'b0;
        #1;
        checkOutput("T6_outs_zero", {num, insert, finish, game_rst, busy, done, err, prize, digits, games, wins}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 20'h12345, fi, da, ea, nr, ni);
        checkOutput("T6_rst_cnt", nr, 1);
        checkOutput("T6_ins_cnt", ni, 5);
        checkOutput("T6_digits", digits, 20'h12345);
        @(negedge clk);
        checkOutput("T6_games", games, 1);
        checkOutput("T6_wins", wins, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
